// File: rtl/btn_debounce_array.sv
// Multi-channel push-button debouncer with hysteresis and optional auto-repeat.
//
// Each channel:
//   btn -> 2-flop synchroniser -> saturating up/down integration counter
//   -> hysteresis comparator (HI_TH / LO_TH) -> registered level,
//      rise/fall edge pulses and press pulses (rise plus optional repeats).
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   btn    in   [CHANNELS] raw asynchronous button inputs
//   level  out  [CHANNELS] debounced button state
//   rise   out  [CHANNELS] one-cycle pulse on level 0->1
//   fall   out  [CHANNELS] one-cycle pulse on level 1->0
//   press  out  [CHANNELS] rise pulse plus auto-repeat pulses when REPEAT_EN=1
module btn_debounce_array #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned HI_TH         = 100000,
    parameter int unsigned LO_TH         = 50000,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam logic [CNT_W-1:0] HiTh   = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0] LoTh   = CNT_W'(LO_TH);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [31:0]      RepDelayM1  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0]      RepPeriodM1 = 32'(REPEAT_PERIOD - 1);

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [31:0]         rc_q  [CHANNELS];
    logic [31:0]         rc_d  [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] press_q, press_d;

    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            // Saturating integrator, never wraps.
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i]) begin
                if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end

            // Hysteresis: between the thresholds the level holds.
            level_d[i] = level_q[i];
            if (cnt_q[i] >= HiTh) begin
                level_d[i] = 1'b1;
            end else if (cnt_q[i] <= LoTh) begin
                level_d[i] = 1'b0;
            end

            rise_d[i] = level_d[i] & ~level_q[i];
            fall_d[i] = ~level_d[i] & level_q[i];

            rc_d[i]    = '0;
            press_d[i] = rise_d[i];
            if (REPEAT_EN != 0) begin
                // Decisions use the post-update level so the fall edge never
                // emits a repeat pulse.
                if (!level_d[i]) begin
                    rc_d[i]    = '0;
                    press_d[i] = 1'b0;
                end else if (rise_d[i]) begin
                    rc_d[i]    = RepDelayM1;
                    press_d[i] = 1'b1;
                end else if (rc_q[i] == '0) begin
                    rc_d[i]    = RepPeriodM1;
                    press_d[i] = 1'b1;
                end else begin
                    rc_d[i]    = rc_q[i] - 32'd1;
                    press_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
                rc_q[i]  <= '0;
            end
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= cnt_d[i];
                rc_q[i]  <= rc_d[i];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign press = press_q;

endmodule

// File: doc/btn_debounce_array.md
BTN_DEBOUNCE_ARRAY -- requirements
Module: btn_debounce_array

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- CHANNELS, 4: number of independent button channels.
- CNT_W, 20: width of each per-channel integration counter.
- HI_TH, 100000: counter value at or above which a channel is judged pressed.
- LO_TH, 50000: counter value at or below which a channel is judged released.
- REPEAT_EN, 0: 1 enables auto-repeat press pulses.
- REPEAT_DELAY, 50000000: cycles from the press edge to the first repeat pulse.
- REPEAT_PERIOD, 10000000: cycles between later repeat pulses.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1: the single clock; all logic is clocked on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- btn, input, CHANNELS: raw asynchronous button inputs.
- level, output, CHANNELS: debounced button state, registered.
- rise, output, CHANNELS: 1-cycle pulse when level goes 0->1.
- fall, output, CHANNELS: 1-cycle pulse when level goes 1->0.
- press, output, CHANNELS: 1-cycle pulse on rise, plus auto-repeat pulses when REPEAT_EN=1.
REQ-003 Parameters SHALL satisfy 0 <= LO_TH < HI_TH <= 2^CNT_W-1, REPEAT_DELAY >= 1 and REPEAT_PERIOD >= 1; the RTL SHALL be written assuming these hold.

Function
REQ-004 Each channel SHALL pass btn through a 2-flip-flop synchroniser; only the second-stage output (sync) SHALL feed later logic.
REQ-005 Each channel SHALL have a CNT_W-bit counter that updates every cycle:
- sync=1: increment, saturating at 2^CNT_W-1.
- sync=0: decrement, saturating at 0.
- No wrap-around in either direction.
REQ-006 The next level value SHALL be computed from the registered counter value:
- 1 if count >= HI_TH.
- 0 if count <= LO_TH.
- Otherwise hold the current level (hysteresis).
REQ-007 level, rise, fall and press SHALL all be registered and update on the same edge.
- rise = 1 exactly on the edge where level goes 0->1.
- fall = 1 exactly on the edge where level goes 1->0.
REQ-008 Press latency SHALL be as follows: if btn is stable high from a reset-cleared channel, and edge 1 is the first edge sampling btn=1, then level and rise SHALL be 1 after edge HI_TH+3.
REQ-009 Release latency SHALL be as follows: if btn goes stable low with count=C >= HI_TH, and edge 1 is the first edge sampling btn=0, then level SHALL be 0 and fall SHALL be 1 after edge C-LO_TH+3.
REQ-010 When REPEAT_EN=0, press SHALL equal rise and the repeat counter SHALL be absent or held at 0.
REQ-011 When REPEAT_EN=1, each channel SHALL have a 32-bit repeat down-counter rc that behaves as follows:
- On the rise edge: press=1 and rc is loaded with REPEAT_DELAY-1.
- Each later cycle with level=1 and rc != 0: rc decrements and press=0.
- A cycle with level=1 and rc == 0: press=1 on that edge and rc is reloaded with REPEAT_PERIOD-1.
- Any edge where level is 0 after the update: rc=0 and press=0.
REQ-012 Press pulses for a held button SHALL therefore occur at edges R, R+REPEAT_DELAY, R+REPEAT_DELAY+REPEAT_PERIOD, and so on, where R is the rise edge.
REQ-013 On the fall edge, press SHALL be 0 even if a repeat pulse was due on that edge.
REQ-014 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.
REQ-015 Bounce shorter than the hysteresis band SHALL NOT produce extra rise, fall or press pulses.

Reset
REQ-016 While rst=1 at a rising edge, the following SHALL be cleared to 0 on that edge, for all channels: synchroniser flops, counters, level, rise, fall, press and rc.
REQ-017 Reset asserted mid-count or mid-repeat SHALL abort the operation without emitting any pulse.
REQ-018 After rst deasserts, each channel SHALL behave as if btn had been 0 indefinitely; a held button SHALL produce a fresh rise after the REQ-008 latency.

Verification (CHANNELS=2, CNT_W=4, HI_TH=8, LO_TH=4, REPEAT_DELAY=5, REPEAT_PERIOD=3)
REQ-019 Press test: btn[0] held at 1 from edge 1 -> level[0]=1 and rise[0]=1 after edge 11 only; the count saturates at 15.
REQ-020 Release test: after saturation, btn[0]=0 from edge 1 -> fall[0]=1 and level[0]=0 after edge 14, with one fall pulse only.
REQ-021 Bounce test: with level=1 and count=15, btn toggles 1/0 each cycle for 40 cycles -> no fall or press pulses and level stays 1. Run the same stimulus starting at level=0 from reset -> no rise pulse and level stays 0.
REQ-022 Repeat test: with REPEAT_EN=1, btn[1] held with rise at edge R -> press[1]=1 at exactly R, R+5, R+8 and R+11 while held. Releasing the button -> press stops, with no pulse on the fall edge.
REQ-023 Reset test: rst=1 for 1 cycle while count=6, rising, and on a second run mid-repeat with rc=2 -> all outputs 0 and no pulse in either run. The held button then gives rise 11 edges after rst is released.
REQ-024 Independence test: both channels pressed simultaneously, with channel 1 released 3 cycles later -> each channel's pulses match the single-channel timing of REQ-019 and REQ-020.
